// File: rtl/uart_inst_loader_if.sv
// rtl/uart_inst_loader_if.sv - instruction-memory write port bundle
// master drives the request/word, slave returns the grant.
interface uart_inst_loader_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req_o;
  logic                  mem_gnt_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic [3:0]            mem_be_o;

  modport master (
    output mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i
  );
endinterface

// File: rtl/uart_inst_loader.sv
// rtl/uart_inst_loader.sv - UART 8N1 program loader into instruction memory
// Bytes are packed little-endian into words and written at consecutive word addresses.
module uart_inst_loader #(
  parameter int                    CLKS_PER_BIT = 10417,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    MAX_WORDS    = 4096,
  parameter int                    IDLE_BITS    = 48
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                uart_rx_inst,
  uart_inst_loader_if.master  mem,
  output logic                boot_done_o,
  output logic                busy_o,
  output logic [15:0]         word_count_o,
  output logic                frame_err_o,
  output logic                overrun_o
);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
  localparam int IDLE_W = $clog2(IDLE_BITS + 1);
  localparam logic [CNT_W-1:0]  HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BITS);
  localparam logic [15:0]       MAX_CNT   = 16'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LD_WAIT_FIRST, LD_LOAD, LD_DONE} ld_state_t;

  rx_state_t         rx_state, rx_state_n;
  ld_state_t         ld_state, ld_state_n;
  logic              rx_meta, rx_sync, rx_prev, fall;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [7:0]        rx_byte, rx_byte_n;
  logic              byte_valid, frame_err;
  logic [1:0]        byte_sel;
  logic [31:0]       word_acc, new_word;
  logic [CNT_W-1:0]  idle_tick;
  logic [IDLE_W-1:0] idle_bits;
  logic              load_done, grant, at_max, timeout, go_done;
  logic              take_byte, word_done, flush, buf_load;

  // Preset to 1 so reset does not look like a start edge on an idle line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) {rx_meta, rx_sync, rx_prev} <= 3'b111;
    else       {rx_meta, rx_sync, rx_prev} <= {uart_rx_inst, rx_meta, rx_sync};
  end
  assign fall = ~rx_sync & rx_prev;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state <= RX_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
    end else begin
      rx_state <= rx_state_n;
      bit_cnt  <= bit_cnt_n;
      bit_idx  <= bit_idx_n;
      rx_byte  <= rx_byte_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    bit_cnt_n  = bit_cnt + 1'b1;
    bit_idx_n  = bit_idx;
    rx_byte_n  = rx_byte;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        bit_cnt_n = '0;
        if (fall && !load_done) rx_state_n = RX_START;
      end
      RX_START: if (bit_cnt == HALF_BIT) begin
        bit_cnt_n  = '0;
        bit_idx_n  = '0;
        rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (bit_cnt == LAST_TICK) begin
        bit_cnt_n = '0;
        rx_byte_n = {rx_sync, rx_byte[7:1]};
        bit_idx_n = bit_idx + 1'b1;
        if (bit_idx == 3'd7) rx_state_n = RX_STOP;
      end
      RX_STOP: if (bit_cnt == LAST_TICK) begin
        bit_cnt_n  = '0;
        rx_state_n = RX_IDLE;
        byte_valid = rx_sync & ~load_done;
        frame_err  = ~rx_sync & ~load_done;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign load_done = (ld_state == LD_DONE);
  assign grant     = mem.mem_req_o & mem.mem_gnt_i;
  assign at_max    = (word_count_o == MAX_CNT);
  assign timeout   = (idle_bits == IDLE_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ld_state <= LD_WAIT_FIRST;
    else       ld_state <= ld_state_n;
  end

  // A partial word must be flushed (byte_sel back to 0) before a timeout may finish the load.
  always_comb begin
    ld_state_n = ld_state;
    go_done    = 1'b0;
    unique case (ld_state)
      LD_WAIT_FIRST: if (byte_valid) ld_state_n = LD_LOAD;
      LD_LOAD: if (!mem.mem_req_o && (at_max || (timeout && byte_sel == 2'd0))) begin
        go_done    = 1'b1;
        ld_state_n = LD_DONE;
      end
      LD_DONE: ld_state_n = LD_DONE;
      default: ld_state_n = LD_WAIT_FIRST;
    endcase
  end

  assign busy_o      = (ld_state == LD_LOAD);
  assign boot_done_o = load_done;

  assign take_byte = byte_valid & ~go_done;
  assign word_done = take_byte & (byte_sel == 2'd3);
  assign flush     = busy_o & timeout & (byte_sel != 2'd0) & ~mem.mem_req_o & ~byte_valid;
  assign new_word  = word_done ? {rx_byte, word_acc[23:0]} : word_acc;
  assign buf_load  = (word_done | flush) & (~mem.mem_req_o | mem.mem_gnt_i);
  assign mem.mem_be_o = 4'hF;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_sel        <= '0;
      word_acc        <= '0;
      mem.mem_req_o   <= 1'b0;
      mem.mem_addr_o  <= BASE_ADDR;
      mem.mem_wdata_o <= '0;
      word_count_o    <= '0;
      overrun_o       <= 1'b0;
      frame_err_o     <= 1'b0;
      idle_tick       <= '0;
      idle_bits       <= '0;
    end else begin
      frame_err_o <= frame_err;
      // Byte 0 of each word clears the upper bytes, which gives the zero padding on flush.
      if (take_byte) begin
        byte_sel <= byte_sel + 1'b1;
        if (byte_sel == 2'd0) word_acc <= {24'h0, rx_byte};
        else                  word_acc[8*byte_sel +: 8] <= rx_byte;
      end else if (flush) begin
        byte_sel <= '0;
      end
      if (grant) begin
        mem.mem_addr_o <= mem.mem_addr_o + ADDR_WIDTH'(4);
        word_count_o   <= word_count_o + 16'd1;
      end
      if (buf_load) begin
        mem.mem_req_o   <= 1'b1;
        mem.mem_wdata_o <= new_word;
      end else if (grant) begin
        mem.mem_req_o <= 1'b0;
      end
      if (word_done && mem.mem_req_o && !mem.mem_gnt_i) overrun_o <= 1'b1;
      if (take_byte) begin
        idle_tick <= '0;
        idle_bits <= '0;
      end else if (busy_o && rx_state == RX_IDLE && !timeout) begin
        if (idle_tick == LAST_TICK) begin
          idle_tick <= '0;
          idle_bits <= idle_bits + 1'b1;
        end else begin
          idle_tick <= idle_tick + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_inst_loader.sv
// tb/tb_uart_inst_loader.sv - randomized self-checking bench for uart_inst_loader
`timescale 1ns/1ps
module tb_uart_inst_loader;
  localparam int CPB  = 16;
  localparam int IDLE = 48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        boot_done, busy, frame_err, overrun;
  logic [15:0] word_count;
  int          n_vec = 0;
  int          n_err = 0;

  uart_inst_loader_if #(.ADDR_WIDTH(32)) mem_if ();

  uart_inst_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_WIDTH(32), .BASE_ADDR(32'h0),
    .MAX_WORDS(4096), .IDLE_BITS(IDLE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .uart_rx_inst(rx), .mem(mem_if),
    .boot_done_o(boot_done), .busy_o(busy), .word_count_o(word_count),
    .frame_err_o(frame_err), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [3:0]  wr_be[$];
  int          fe_count = 0;

  // Grants happen at the next rising edge; inputs only move just after rising edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_if.mem_req_o && mem_if.mem_gnt_i) begin
        wr_addr.push_back(mem_if.mem_addr_o);
        wr_data.push_back(mem_if.mem_wdata_o);
        wr_be.push_back(mem_if.mem_be_o);
      end
      if (frame_err) fe_count++;
    end
  end

  logic [7:0]  tx_b[$];
  bit          tx_bad[$];
  logic [31:0] exp_w[$];
  int          exp_fe;
  int          wr_base, fe_base;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rx = 1'b1; mem_if.mem_gnt_i = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    wr_base = wr_data.size();
    fe_base = fe_count;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rx = b[i]; tick(CPB); end
    rx = ~bad; tick(CPB);
    rx = 1'b1;
    if (bad) tick(2);
  endtask

  task automatic set_tx(input logic [63:0] bytes, input int n, input logic [7:0] bad_mask);
    tx_b.delete(); tx_bad.delete();
    for (int i = 0; i < n; i++) begin
      tx_b.push_back(bytes[8*i +: 8]);
      tx_bad.push_back(bad_mask[i]);
    end
  endtask

  // Reference: drop bad-stop bytes, pack survivors in fours, little-endian, zero-padded tail.
  task automatic model_words();
    logic [7:0]  good[$];
    logic [31:0] w;
    exp_w.delete();
    exp_fe = 0;
    foreach (tx_b[i]) begin
      if (tx_bad[i]) exp_fe++;
      else good.push_back(tx_b[i]);
    end
    for (int i = 0; i < good.size(); i += 4) begin
      w = 32'h0;
      for (int k = 0; k < 4 && i + k < good.size(); k++) w = w | (32'(good[i+k]) << (8*k));
      exp_w.push_back(w);
    end
  endtask

  task automatic send_all();
    foreach (tx_b[i]) send_byte(tx_b[i], tx_bad[i]);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (boot_done) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; mem_if.mem_gnt_i = 1'b1;
    tick(3);
    @(negedge clk);
    n_vec++;
    if ({mem_if.mem_req_o, boot_done, busy, frame_err, overrun} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 00000", {mem_if.mem_req_o, boot_done, busy, frame_err, overrun});
    end
    n_vec++;
    if (mem_if.mem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 00000000", mem_if.mem_addr_o); end
    n_vec++;
    if (word_count !== 16'd0 || mem_if.mem_wdata_o !== 32'h0) begin
      n_err++; $display("FAIL reset_count_wdata got %0d/%h want 0/00000000", word_count, mem_if.mem_wdata_o);
    end
  endtask

  task automatic test_single_word();
    bit ok;
    do_reset();
    set_tx(64'h00_20_01_13, 4, 8'h00);
    send_all();
    tick(720);
    n_vec++;
    if (boot_done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL single_early_done got done=%b busy=%b want 0/1", boot_done, busy); end
    n_vec++;
    if (wr_data.size() - wr_base !== 1) begin n_err++; $display("FAIL single_nwrites got %0d want 1", wr_data.size() - wr_base); end
    if (wr_data.size() > wr_base) begin
      n_vec++;
      if (wr_data[wr_base] !== 32'h00200113 || wr_addr[wr_base] !== 32'h0 || wr_be[wr_base] !== 4'hF) begin
        n_err++; $display("FAIL single_write got %h@%h be %h want 00200113@00000000 be f", wr_data[wr_base], wr_addr[wr_base], wr_be[wr_base]);
      end
    end
    wait_done(200, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL single_done_timeout got 0 want 1"); end
    n_vec++;
    if (word_count !== 16'd1 || busy !== 1'b0) begin n_err++; $display("FAIL single_final got count=%0d busy=%b want 1/0", word_count, busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tx_b.delete(); tx_bad.delete();
    for (int i = 0; i < 12; i++) begin tx_b.push_back(8'($urandom)); tx_bad.push_back(1'b0); end
    model_words();
    send_all();
    tick(20);
    n_vec++;
    if (wr_data.size() - wr_base !== exp_w.size()) begin n_err++; $display("FAIL b2b_nwrites got %0d want %0d", wr_data.size() - wr_base, exp_w.size()); end
    for (int i = 0; i < exp_w.size() && wr_base + i < wr_data.size(); i++) begin
      n_vec++;
      if (wr_data[wr_base+i] !== exp_w[i] || wr_addr[wr_base+i] !== 32'(4*i)) begin
        n_err++; $display("FAIL b2b_write%0d got %h@%h want %h@%h", i, wr_data[wr_base+i], wr_addr[wr_base+i], exp_w[i], 32'(4*i));
      end
    end
    n_vec++;
    if (word_count !== 16'd3 || overrun !== 1'b0 || fe_count - fe_base !== 0) begin
      n_err++; $display("FAIL b2b_status got count=%0d ovr=%b fe=%0d want 3/0/0", word_count, overrun, fe_count - fe_base);
    end
  endtask

  task automatic test_frame_error();
    bit ok;
    do_reset();
    set_tx(64'hEE_DD_CC_BB_AA, 5, 8'b0000_0010);
    send_all();
    tick(20);
    n_vec++;
    if (fe_count - fe_base !== 1) begin n_err++; $display("FAIL ferr_pulses got %0d want 1", fe_count - fe_base); end
    wait_done(1000, ok);
    n_vec++;
    if (!ok || wr_data.size() - wr_base !== 1) begin n_err++; $display("FAIL ferr_nwrites got done=%b n=%0d want 1/1", ok, wr_data.size() - wr_base); end
    if (wr_data.size() > wr_base) begin
      n_vec++;
      if (wr_data[wr_base] !== 32'hEEDDCCAA || wr_addr[wr_base] !== 32'h0) begin
        n_err++; $display("FAIL ferr_write got %h@%h want eeddccaa@00000000", wr_data[wr_base], wr_addr[wr_base]);
      end
    end
  endtask

  task automatic test_partial_word();
    bit ok;
    do_reset();
    set_tx(64'h06_05_04_03_02_01, 6, 8'h00);
    send_all();
    tick(20);
    n_vec++;
    if (wr_data.size() - wr_base !== 1) begin n_err++; $display("FAIL partial_before_idle got %0d want 1", wr_data.size() - wr_base); end
    wait_done(1000, ok);
    n_vec++;
    if (!ok || wr_data.size() - wr_base !== 2 || word_count !== 16'd2) begin
      n_err++; $display("FAIL partial_done got done=%b n=%0d count=%0d want 1/2/2", ok, wr_data.size() - wr_base, word_count);
    end
    if (wr_data.size() >= wr_base + 2) begin
      n_vec++;
      if (wr_data[wr_base] !== 32'h04030201 || wr_addr[wr_base] !== 32'h0) begin
        n_err++; $display("FAIL partial_w0 got %h@%h want 04030201@00000000", wr_data[wr_base], wr_addr[wr_base]);
      end
      n_vec++;
      if (wr_data[wr_base+1] !== 32'h00000605 || wr_addr[wr_base+1] !== 32'h4) begin
        n_err++; $display("FAIL partial_w1 got %h@%h want 00000605@00000004", wr_data[wr_base+1], wr_addr[wr_base+1]);
      end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    mem_if.mem_gnt_i = 1'b0;
    tx_b.delete(); tx_bad.delete();
    for (int i = 0; i < 8; i++) begin tx_b.push_back(8'($urandom)); tx_bad.push_back(1'b0); end
    model_words();
    send_all();
    tick(5);
    n_vec++;
    if (overrun !== 1'b1 || mem_if.mem_req_o !== 1'b1) begin n_err++; $display("FAIL ovr_flags got ovr=%b req=%b want 1/1", overrun, mem_if.mem_req_o); end
    n_vec++;
    if (mem_if.mem_wdata_o !== exp_w[0] || mem_if.mem_addr_o !== 32'h0) begin
      n_err++; $display("FAIL ovr_pending got %h@%h want %h@00000000", mem_if.mem_wdata_o, mem_if.mem_addr_o, exp_w[0]);
    end
    mem_if.mem_gnt_i = 1'b1;
    tick(5);
    n_vec++;
    if (wr_data.size() - wr_base !== 1 || word_count !== 16'd1 || mem_if.mem_req_o !== 1'b0) begin
      n_err++; $display("FAIL ovr_release got n=%0d count=%0d req=%b want 1/1/0", wr_data.size() - wr_base, word_count, mem_if.mem_req_o);
    end
    if (wr_data.size() > wr_base) begin
      n_vec++;
      if (wr_data[wr_base] !== exp_w[0]) begin n_err++; $display("FAIL ovr_write got %h want %h", wr_data[wr_base], exp_w[0]); end
    end
    wait_done(1000, ok);
    n_vec++;
    if (!ok || wr_data.size() - wr_base !== 1) begin n_err++; $display("FAIL ovr_done got done=%b n=%0d want 1/1", ok, wr_data.size() - wr_base); end
  endtask

  task automatic test_glitch_and_midreset();
    do_reset();
    rx = 1'b0; tick(1); rx = 1'b1;
    tick(3*CPB);
    n_vec++;
    if (busy !== 1'b0 || fe_count - fe_base !== 0 || wr_data.size() - wr_base !== 0) begin
      n_err++; $display("FAIL glitch got busy=%b fe=%0d n=%0d want 0/0/0", busy, fe_count - fe_base, wr_data.size() - wr_base);
    end
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b0);
    rx = 1'b0; tick(CPB); rx = 1'b1; tick(2*CPB); rx = 1'b0; tick(CPB/2);
    do_reset();
    tx_b.delete(); tx_bad.delete();
    for (int i = 0; i < 4; i++) begin tx_b.push_back(8'($urandom)); tx_bad.push_back(1'b0); end
    model_words();
    send_all();
    tick(20);
    n_vec++;
    if (wr_data.size() - wr_base !== 1 || word_count !== 16'd1 || fe_count - fe_base !== 0) begin
      n_err++; $display("FAIL midrst_status got n=%0d count=%0d fe=%0d want 1/1/0", wr_data.size() - wr_base, word_count, fe_count - fe_base);
    end
    if (wr_data.size() > wr_base) begin
      n_vec++;
      if (wr_data[wr_base] !== exp_w[0] || wr_addr[wr_base] !== 32'h0) begin
        n_err++; $display("FAIL midrst_write got %h@%h want %h@00000000", wr_data[wr_base], wr_addr[wr_base], exp_w[0]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      n = $urandom_range(1, 10);
      tx_b.delete(); tx_bad.delete();
      for (int i = 0; i < n; i++) begin
        tx_b.push_back(8'($urandom));
        tx_bad.push_back(i > 0 && $urandom_range(0, 4) == 0);
      end
      model_words();
      send_all();
      wait_done(1200, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL rnd%0d_done got 0 want 1", it); end
      n_vec++;
      if (wr_data.size() - wr_base !== exp_w.size() || 32'(word_count) !== 32'(exp_w.size())) begin
        n_err++; $display("FAIL rnd%0d_nwrites got n=%0d count=%0d want %0d", it, wr_data.size() - wr_base, word_count, exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && wr_base + i < wr_data.size(); i++) begin
        n_vec++;
        if (wr_data[wr_base+i] !== exp_w[i] || wr_addr[wr_base+i] !== 32'(4*i) || wr_be[wr_base+i] !== 4'hF) begin
          n_err++; $display("FAIL rnd%0d_write%0d got %h@%h be %h want %h@%h be f", it, i, wr_data[wr_base+i], wr_addr[wr_base+i], wr_be[wr_base+i], exp_w[i], 32'(4*i));
        end
      end
      n_vec++;
      if (fe_count - fe_base !== exp_fe || overrun !== 1'b0) begin
        n_err++; $display("FAIL rnd%0d_errs got fe=%0d ovr=%b want %0d/0", it, fe_count - fe_base, overrun, exp_fe);
      end
    end
  endtask

  initial begin
    mem_if.mem_gnt_i = 1'b1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_frame_error();
    test_partial_word();
    test_overrun();
    test_glitch_and_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_inst_loader.md
Name: uart_inst_loader

Overview:
- On-chip responder for the UART program-load stream: receives 8N1 bytes on uart_rx_inst, assembles them little-endian into 32-bit instruction words, and writes them to instruction memory at consecutive word addresses.
- Sits between the uart_rx_inst pad and the instruction-memory write port. Holds the core off, via boot_done_o, until loading completes.

Parameters:
- CLKS_PER_BIT, 10417, clocks per UART bit (100 MHz / 9600 baud + 1).
- ADDR_WIDTH, 32, width of the byte address on mem_addr_o.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- MAX_WORDS, 4096, load terminates after this many words.
- IDLE_BITS, 48, idle bit-periods after the last received byte that end the load.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- uart_rx_inst  in  1  serial input; idle high; asynchronous to clk_i.
- mem_req_o  out  1  write request; held until granted.
- mem_gnt_i  in  1  write accepted on the cycle where mem_req_o and mem_gnt_i are both 1.
- mem_addr_o  out  ADDR_WIDTH  byte address of the word; word aligned.
- mem_wdata_o  out  32  instruction word.
- mem_be_o  out  4  byte enables; constant 4'hF.
- boot_done_o  out  1  sticky; load finished.
- busy_o  out  1  at least one byte received and load not yet done.
- word_count_o  out  16  number of words granted so far.
- frame_err_o  out  1  one-cycle pulse on a bad stop bit.
- overrun_o  out  1  sticky; a word completed while the previous word was still ungranted.

Behaviour:
- Reset, asynchronous:
  - All outputs 0, except mem_addr_o = BASE_ADDR.
  - RX FSM goes to IDLE; byte index = 0; loader goes to WAIT_FIRST.
  - Synchronizer flops are preset to 1.
  - Reset mid-frame or mid-word discards all partial state.
- Input sync: 2-flop synchronizer. A falling edge is detected as sync = 0 while the previous sync value = 1.
- RX FSM:
  - IDLE -> START on a falling edge; bit counter cleared.
  - START: at CLKS_PER_BIT/2 (integer division), if sync = 1 this is a glitch -> IDLE; otherwise counter cleared -> DATA.
  - DATA: sample every CLKS_PER_BIT clocks (mid-bit). 8 bits, LSB first, shifted into the byte register -> STOP.
  - STOP: sample after CLKS_PER_BIT. If sync = 1, byte_valid pulses for 1 cycle. If sync = 0, frame_err_o pulses and the byte is dropped; the byte index is not advanced. Either way -> IDLE in the same cycle.
  - A start edge is recognised the cycle after return to IDLE, so back-to-back frames are supported.
- Word assembly:
  - Byte k (k = 0..3) goes to word[8k+7:8k]; for example bytes 0x13, 0x01, 0x20, 0x00 give 0x00200113.
  - On byte 3, the word is copied to the write buffer and the byte index wraps to 0.
- Write port:
  - Buffer load sets mem_req_o the next cycle, with mem_wdata_o and mem_addr_o stable until the grant.
  - On a grant: mem_req_o falls next cycle, mem_addr_o += 4, word_count_o += 1.
  - If a new word completes while mem_req_o = 1: overrun_o is set, the new word is dropped, and the pending request is unaffected.
  - Address wraps modulo 2^ADDR_WIDTH.
- Loader FSM:
  - WAIT_FIRST -> LOAD on the first byte_valid; busy_o = 1 in LOAD.
  - The idle counter resets on every byte_valid and counts bit-periods while RX is IDLE.
  - LOAD -> DONE when either:
    - (word_count_o reaches MAX_WORDS and mem_req_o = 0), or
    - (idle counter = IDLE_BITS and mem_req_o = 0).
  - A partial word at the idle timeout is zero-padded in its upper bytes and written first; DONE follows that grant.
  - DONE: boot_done_o = 1, busy_o = 0. Further UART input is ignored, including framing checks. Only reset leaves DONE.
- Simultaneous events:
  - A grant in the same cycle a new word completes is not an overrun; the new word loads into the buffer.
  - A frame error in the same cycle as the idle timeout is irrelevant, because timeout counting only runs in RX IDLE.

Test Plan:
- CLKS_PER_BIT = 16, mem_gnt_i tied to 1. Send 0x13, 0x01, 0x20, 0x00 -> one write, addr 0x0, wdata 0x00200113, be 4'hF; word_count_o = 1; boot_done_o = 1 after 48 idle bit-periods.
- Send 12 bytes as 3 back-to-back words -> writes to 0x0, 0x4, 0x8; word_count_o = 3; no errors.
- Stop bit forced to 0 on the 2nd byte of 0xAA, 0xBB, 0xCC, 0xDD, 0xEE -> frame_err_o pulses once; the word written is 0xEEDDCCAA.
- Send 6 bytes 0x01..0x06 then idle -> writes 0x04030201 @0x0, then 0x00000605 @0x4, then boot_done_o = 1.
- mem_gnt_i held 0 through two full words -> overrun_o = 1; on release of the grant exactly one write (word 1) occurs; word_count_o = 1.
- 1-clock low glitch on idle line -> no byte, no frame_err_o. Assert rst_i mid-byte, release, send a full word -> clean write at BASE_ADDR.
